data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 16-bit words held; power of two, 2..65536.
REQ-002 Parameter WAIT_CYCLES, default 2, extra latency cycles per access; range 0..15.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port proc_rst, input, 1, synchronous active-high reset.
REQ-005 Port req_valid, input, 1, the processor presents a request.
REQ-006 Port req_write, input, 1, 1 = store, 0 = load.
REQ-007 Port req_addr, input, 16, word address.
REQ-008 Port req_wdata, input, 16, store data.
REQ-009 Port req_ready, output, 1, the responder can accept a request this cycle.
REQ-010 Port rsp_valid, output, 1, the response is presented.
REQ-011 Port rsp_rdata, output, 16, load data.
REQ-012 Port rsp_err, output, 1, the address is out of range.
REQ-013 Port rsp_ready, input, 1, the processor accepts the response.

Function
REQ-014 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 IDLE: req_ready SHALL be 1 and rsp_valid SHALL be 0.
- A request is accepted at a clock edge where req_valid=1 and req_ready=1.
- On acceptance, the block SHALL latch req_write, req_addr and req_wdata.
REQ-016 From IDLE, on acceptance, the next state SHALL be WAIT with the counter loaded to WAIT_CYCLES; when WAIT_CYCLES=0 the next state SHALL be RESP.
REQ-017 WAIT: req_ready SHALL be 0.
- The counter decrements once per cycle.
- When the counter equals 1, the next state SHALL be RESP.
REQ-018 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-019 A store SHALL update the array on the edge that enters RESP. A load SHALL register the array word into rsp_rdata on that same edge.
REQ-020 RESP: rsp_valid SHALL be 1, req_ready SHALL be 0, and rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_ready=1.
- On that edge the next state SHALL be IDLE.
- No new request SHALL be accepted on that edge.
REQ-021 A store response SHALL drive rsp_rdata=16'h0000.
REQ-022 An address req_addr >= DEPTH SHALL set rsp_err=1, suppress the store, and return rsp_rdata=16'h0000. An in-range address SHALL set rsp_err=0.
REQ-023 Request inputs SHALL be ignored outside IDLE. The latched values SHALL NOT change while in WAIT or RESP.
REQ-024 If rsp_ready is already 1 when rsp_valid rises, the response SHALL complete in one cycle. The minimum transaction is WAIT_CYCLES+2 cycles from acceptance back to IDLE.
REQ-025 A load from an address that has never been written returns undefined data; the bench SHALL NOT check it.

Reset
REQ-026 When proc_rst=1 at an edge, the outputs SHALL be:
- state=IDLE and counter=0
- req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0
REQ-027 Reset SHALL apply in any state. A transaction in flight SHALL be dropped with no response. A store not yet performed SHALL NOT be written.
REQ-028 Reset SHALL NOT clear the storage array; its contents persist across reset.

Structure
REQ-029 The shared package proc_pkg SHALL hold WORD_W=16, the FSM state enum (IDLE/WAIT/RESP) and the rsp_rdata store value.
REQ-030 The counter width SHALL be $clog2(WAIT_CYCLES+1), with a minimum of 1.
REQ-031 One sub-module SHALL exist: data_mem_array, a DEPTH x 16 single-port array with synchronous write and combinational read, instantiated once.

Verification
REQ-032 WAIT_CYCLES=2. Store 16'hBEEF to address 5 with rsp_ready held at 1.
- rsp_valid=1 on the 3rd edge after acceptance with rsp_err=0.
- A subsequent load of address 5 returns 16'hBEEF.
REQ-033 WAIT_CYCLES=0. Back-to-back loads of addresses 5 and 6 with rsp_ready=1.
- Each response arrives 1 cycle after acceptance.
- req_ready is low during RESP.
- The two loads are accepted 2 cycles apart.
REQ-034 Backpressure: hold rsp_ready=0 for 4 cycles during a load of address 5.
- rsp_valid, rsp_rdata=16'hBEEF and rsp_err stay stable throughout.
- The block returns to IDLE 1 edge after rsp_ready rises.
REQ-035 DEPTH=256. Store 16'h1234 to address 16'h0100.
- rsp_err=1.
- A load of address 0 is unchanged.
- A load of 16'h0100 returns 16'h0000 with rsp_err=1.
REQ-036 Changing req_addr and req_wdata while in WAIT SHALL NOT alter the transaction.
REQ-037 Assert proc_rst in WAIT during a store of 16'h5555 to address 7.
- No response is produced.
- req_ready=1 on the next cycle.
- Address 7 keeps its prior value.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor data-memory responder: word width,
// responder FSM states, the read-data value returned for stores and errors,
// and the address range helper.
package proc_pkg;

  localparam int WORD_W = 16;

  // Value presented on rsp_rdata for store responses and out-of-range accesses.
  localparam logic [WORD_W-1:0] STORE_RDATA = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An address is valid only when it falls inside the configured array depth.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                         input int depth);
    return {16'h0000, addr} < depth;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x WORD_W single-port storage: synchronous write, combinational read.
module data_mem_array
  import proc_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port: store the word on the rising edge when enabled.
  // NOTE: the storage has no reset on purpose; contents survive a responder
  // reset and a reset branch here would also stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Processor data-memory responder: accepts one load/store request at a time,
// waits WAIT_CYCLES cycles, performs the access and holds the response until
// the processor takes it.
module data_mem_responder
  import proc_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        proc_rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lat_write_q;
  logic [WORD_W-1:0]  lat_addr_q;
  logic [WORD_W-1:0]  lat_wdata_q;
  logic [WORD_W-1:0]  rdata_q;
  logic               err_q;

  logic               accept;
  logic               enter_resp;
  logic               cur_write;
  logic [WORD_W-1:0]  cur_addr;
  logic [WORD_W-1:0]  cur_wdata;
  logic               in_range;
  logic               mem_we;
  logic [WORD_W-1:0]  mem_rdata;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept = req_valid && req_ready;

  // With zero wait cycles the access happens on the acceptance edge itself,
  // so the live request is used in IDLE and the latched copy otherwise.
  assign cur_write = (state_q == IDLE) ? req_write : lat_write_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : lat_addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : lat_wdata_q;

  assign in_range = addr_in_range(cur_addr, DEPTH);
  assign mem_we   = enter_resp && cur_write && in_range && !proc_rst;

  data_mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_addr[ADDR_W-1:0]),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, hand off in RESP.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, request latch and response registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_write_q <= req_write;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= !in_range;
        rdata_q <= (cur_write || !in_range) ? STORE_RDATA : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with WAIT_CYCLES=2
// (side a) and one with WAIT_CYCLES=0 (side b), both DEPTH=256.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic proc_rst = 1'b0;

  logic        req_valid_a = 1'b0, req_write_a = 1'b0, rsp_ready_a = 1'b1;
  logic [15:0] req_addr_a = '0, req_wdata_a = '0;
  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [15:0] rsp_rdata_a;

  logic        req_valid_b = 1'b0, req_write_b = 1'b0, rsp_ready_b = 1'b1;
  logic [15:0] req_addr_b = '0, req_wdata_b = '0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [15:0] rsp_rdata_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .proc_rst(proc_rst),
    .req_valid(req_valid_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .req_ready(req_ready_a), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .rsp_ready(rsp_ready_a)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .proc_rst(proc_rst),
    .req_valid(req_valid_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .rsp_ready(rsp_ready_b)
  );

  task automatic drive_req(input bit sel, input logic v, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
    if (sel) begin
      req_valid_b = v; req_write_b = w; req_addr_b = a; req_wdata_b = d;
    end else begin
      req_valid_a = v; req_write_a = w; req_addr_a = a; req_wdata_a = d;
    end
  endtask

  // {rsp_valid, rsp_err, rsp_rdata} of the selected instance.
  function automatic logic [17:0] rsp_of(input bit sel);
    return sel ? {rsp_valid_b, rsp_err_b, rsp_rdata_b}
               : {rsp_valid_a, rsp_err_a, rsp_rdata_a};
  endfunction

  // One request from IDLE; lat is the first negedge (counted from the
  // acceptance edge) with rsp_valid high, or -1 if none within 20 cycles.
  // With disturb set, the request inputs are scrambled while busy.
  task automatic xact(input bit sel, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input bit disturb,
                      output logic [15:0] rd, output logic er, output int lat);
    logic [17:0] r;
    @(negedge clk);
    drive_req(sel, 1'b1, w, a, d);
    @(posedge clk);
    #1;
    if (disturb) drive_req(sel, 1'b1, ~w, a ^ 16'h0003, ~d);
    else         drive_req(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      r = rsp_of(sel);
      if (r[17]) begin
        lat = k;
        er  = r[16];
        rd  = r[15:0];
        break;
      end
    end
    drive_req(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset();
    proc_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready_a !== 1'b1) $display("FAIL reset_req_ready_a: got %b expected 1", req_ready_a);
    else passed++;
    total++;
    if ({rsp_valid_a, rsp_err_a, rsp_rdata_a} !== 18'h0)
      $display("FAIL reset_rsp_a: got %h expected 0", {rsp_valid_a, rsp_err_a, rsp_rdata_a});
    else passed++;
    total++;
    if ({req_ready_b, rsp_valid_b} !== 2'b10)
      $display("FAIL reset_b: got %b expected 10", {req_ready_b, rsp_valid_b});
    else passed++;
    proc_rst = 1'b0;
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic er; int lat;
    rsp_ready_a = 1'b1;
    xact(0, 1'b1, 16'd5, 16'hBEEF, 0, rd, er, lat);
    total++;
    if (lat !== 3) $display("FAIL store_latency: got %0d expected 3", lat);
    else passed++;
    total++;
    if ({er, rd} !== 17'h0) $display("FAIL store_rsp: got err=%b rdata=%h expected 0/0000", er, rd);
    else passed++;
    @(negedge clk);
    total++;
    if ({req_ready_a, rsp_valid_a} !== 2'b10)
      $display("FAIL store_back_idle: got %b expected 10", {req_ready_a, rsp_valid_a});
    else passed++;
    xact(0, 1'b0, 16'd5, 16'h0000, 0, rd, er, lat);
    total++;
    if ({lat[3:0], er, rd} !== {4'd3, 1'b0, 16'hBEEF})
      $display("FAIL load_5: got lat=%0d err=%b rdata=%h expected 3/0/beef", lat, er, rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int lat;
    xact(1, 1'b1, 16'd5, 16'hBEEF, 0, rd, er, lat);
    total++;
    if (lat !== 1) $display("FAIL b_store_latency: got %0d expected 1", lat);
    else passed++;
    xact(1, 1'b1, 16'd6, 16'h0606, 0, rd, er, lat);
    @(negedge clk);
    drive_req(1, 1'b1, 1'b0, 16'd5, 16'h0000);
    total++;
    if (req_ready_b !== 1'b1) $display("FAIL b2b_ready0: got %b expected 1", req_ready_b);
    else passed++;
    @(negedge clk);
    total++;
    if ({rsp_valid_b, req_ready_b, rsp_err_b, rsp_rdata_b} !== {3'b100, 16'hBEEF})
      $display("FAIL b2b_rsp5: got %h expected 4beef", {rsp_valid_b, req_ready_b, rsp_err_b, rsp_rdata_b});
    else passed++;
    req_addr_b = 16'd6;
    @(negedge clk);
    total++;
    if ({req_ready_b, rsp_valid_b} !== 2'b10)
      $display("FAIL b2b_gap: got %b expected 10", {req_ready_b, rsp_valid_b});
    else passed++;
    @(negedge clk);
    total++;
    if ({rsp_valid_b, req_ready_b, rsp_err_b, rsp_rdata_b} !== {3'b100, 16'h0606})
      $display("FAIL b2b_rsp6: got %h expected 40606", {rsp_valid_b, req_ready_b, rsp_err_b, rsp_rdata_b});
    else passed++;
    drive_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] rd; logic er; int lat;
    rsp_ready_a = 1'b0;
    xact(0, 1'b0, 16'd5, 16'h0000, 0, rd, er, lat);
    total++;
    if ({lat[3:0], er, rd} !== {4'd3, 1'b0, 16'hBEEF})
      $display("FAIL bp_first: got lat=%0d err=%b rdata=%h expected 3/0/beef", lat, er, rd);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid_a, req_ready_a, rsp_err_a, rsp_rdata_a} !== {3'b100, 16'hBEEF})
        $display("FAIL bp_hold%0d: got %h expected 4beef", i,
                 {rsp_valid_a, req_ready_a, rsp_err_a, rsp_rdata_a});
      else passed++;
    end
    rsp_ready_a = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready_a, rsp_valid_a} !== 2'b10)
      $display("FAIL bp_release: got %b expected 10", {req_ready_a, rsp_valid_a});
    else passed++;
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic er; int lat;
    xact(0, 1'b1, 16'd0, 16'hA0A0, 0, rd, er, lat);
    xact(0, 1'b1, 16'h0100, 16'h1234, 0, rd, er, lat);
    total++;
    if ({er, rd} !== {1'b1, 16'h0000})
      $display("FAIL oor_store: got err=%b rdata=%h expected 1/0000", er, rd);
    else passed++;
    xact(0, 1'b0, 16'd0, 16'h0000, 0, rd, er, lat);
    total++;
    if ({er, rd} !== {1'b0, 16'hA0A0})
      $display("FAIL oor_addr0: got err=%b rdata=%h expected 0/a0a0", er, rd);
    else passed++;
    xact(0, 1'b0, 16'h0100, 16'h0000, 0, rd, er, lat);
    total++;
    if ({er, rd} !== {1'b1, 16'h0000})
      $display("FAIL oor_load: got err=%b rdata=%h expected 1/0000", er, rd);
    else passed++;
    xact(0, 1'b1, 16'h00FF, 16'h5A5A, 0, rd, er, lat);
    xact(0, 1'b0, 16'h00FF, 16'h0000, 0, rd, er, lat);
    total++;
    if ({er, rd} !== {1'b0, 16'h5A5A})
      $display("FAIL top_addr: got err=%b rdata=%h expected 0/5a5a", er, rd);
    else passed++;
  endtask

  task automatic test_wait_changes();
    logic [15:0] rd; logic er; int lat;
    xact(0, 1'b1, 16'd10, 16'h1010, 0, rd, er, lat);
    xact(0, 1'b1, 16'd9, 16'h7777, 1, rd, er, lat);
    total++;
    if ({lat[3:0], er, rd} !== {4'd3, 1'b0, 16'h0000})
      $display("FAIL wc_store: got lat=%0d err=%b rdata=%h expected 3/0/0000", lat, er, rd);
    else passed++;
    xact(0, 1'b0, 16'd9, 16'h0000, 0, rd, er, lat);
    total++;
    if (rd !== 16'h7777) $display("FAIL wc_addr9: got %h expected 7777", rd);
    else passed++;
    xact(0, 1'b0, 16'd10, 16'h0000, 0, rd, er, lat);
    total++;
    if (rd !== 16'h1010) $display("FAIL wc_addr10: got %h expected 1010", rd);
    else passed++;
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] rd; logic er; int lat;
    bit quiet;
    xact(0, 1'b1, 16'd7, 16'h0707, 0, rd, er, lat);
    xact(0, 1'b0, 16'd7, 16'h0000, 0, rd, er, lat);
    total++;
    if (rd !== 16'h0707) $display("FAIL rw_preload: got %h expected 0707", rd);
    else passed++;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b1, 16'd7, 16'h5555);
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    total++;
    if ({req_ready_a, rsp_valid_a} !== 2'b00)
      $display("FAIL rw_in_wait: got %b expected 00", {req_ready_a, rsp_valid_a});
    else passed++;
    proc_rst = 1'b1;
    @(negedge clk);
    proc_rst = 1'b0;
    total++;
    if ({req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a} !== {3'b100, 16'h0000})
      $display("FAIL rw_after_rst: got %h expected 40000",
               {req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a});
    else passed++;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid_a) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) $display("FAIL rw_no_rsp: got response after reset");
    else passed++;
    xact(0, 1'b0, 16'd7, 16'h0000, 0, rd, er, lat);
    total++;
    if (rd !== 16'h0707) $display("FAIL rw_addr7: got %h expected 0707", rd);
    else passed++;
    xact(0, 1'b0, 16'd5, 16'h0000, 0, rd, er, lat);
    total++;
    if (rd !== 16'hBEEF) $display("FAIL rw_persist5: got %h expected beef", rd);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_wait_changes();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
